// File: rtl/fb_reader.sv
// Framebuffer read path: fetches 128-bit words in address order under a credit
// limit, buffers them and unpacks MSB-first RGB565 pixels with frame position flags.
module fb_reader #(
    parameter int WIDTH      = 1024,
    parameter int HEIGHT     = 768,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_STEP  = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ram_init_done,
    input  logic         i_frame_restart,
    output logic         o_rd_req,
    output logic [27:0]  o_rd_addr,
    input  logic         i_rd_ack,
    input  logic         i_rd_valid,
    input  logic [127:0] i_rd_data,
    output logic         o_pix_valid,
    input  logic         i_pix_ready,
    output logic [15:0]  o_pix_data,
    output logic         o_pix_sof,
    output logic         o_pix_eol,
    output logic         o_busy
);

    // state | meaning
    // IDLE  | waiting for RAM calibration, nothing requested
    // RUN   | issuing reads under credit and streaming pixels
    // DRAIN | frame aborted; discarding returns until nothing is outstanding

    localparam int WORDS = WIDTH * HEIGHT / 8;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam logic [27:0]   LAST_ADDR = 28'((WORDS - 1) * ADDR_STEP);
    localparam logic [27:0]   STEP      = 28'(ADDR_STEP);
    localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [127:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outstanding;
    logic [2:0]      r_lane;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [27:0]     r_rd_addr;

    logic            w_enter_drain;
    logic            w_credit_ok;
    logic            w_ack;
    logic            w_push;
    logic            w_fire;
    logic            w_pop;
    logic [127:0]    w_head;
    logic [127:0]    w_lane_sh;

    assign w_enter_drain = i_frame_restart &&
                           (r_state == S_RUN || (r_state == S_IDLE && i_ram_init_done));
    // Words in flight plus words held can never exceed the buffer size.
    assign w_credit_ok   = (r_outstanding + r_count) < DEPTH_C;
    assign w_ack         = o_rd_req & i_rd_ack;
    assign w_push        = i_rd_valid && (r_state != S_DRAIN) && !w_enter_drain;
    assign w_fire        = o_pix_valid & i_pix_ready;
    assign w_pop         = w_fire && (r_lane == 3'd7);
    assign w_head        = r_mem[r_rd_ptr];
    assign w_lane_sh     = w_head << {r_lane, 4'b0000};

    always_comb begin
        w_next      = r_state;
        o_rd_req    = 1'b0;
        o_busy      = (r_state != S_IDLE);
        o_pix_valid = (r_state != S_DRAIN) && (r_count != '0);
        case (r_state)
            S_IDLE: begin
                if (w_enter_drain)
                    w_next = S_DRAIN;
                else if (i_ram_init_done)
                    w_next = S_RUN;
            end
            S_RUN: begin
                o_rd_req = i_ram_init_done && w_credit_ok;
                if (i_frame_restart)
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_outstanding == '0)
                    w_next = i_ram_init_done ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign o_rd_addr  = r_rd_addr;
    assign o_pix_data = o_pix_valid ? w_lane_sh[127:112] : 16'h0000;
    assign o_pix_sof  = o_pix_valid && (r_x == '0) && (r_y == '0);
    assign o_pix_eol  = o_pix_valid && (r_x == X_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_lane        <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_rd_addr     <= '0;
        end else begin
            r_state <= w_next;
            if (w_ack && !i_rd_valid)
                r_outstanding <= r_outstanding + CW'(1);
            else if (!w_ack && i_rd_valid)
                r_outstanding <= r_outstanding - CW'(1);
            if (w_enter_drain) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_lane    <= '0;
                r_x       <= '0;
                r_y       <= '0;
                r_rd_addr <= '0;
            end else begin
                if (w_ack)
                    r_rd_addr <= (r_rd_addr == LAST_ADDR) ? 28'd0 : r_rd_addr + STEP;
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_fire) begin
                    r_lane <= r_lane + 3'd1;
                    if (r_x == X_LAST) begin
                        r_x <= '0;
                        r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
                    end else begin
                        r_x <= r_x + XW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_rd_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && i_rd_valid)
            assert (r_count != DEPTH_C);
    end

endmodule
